calc_job_scheduler: RTL and testbench

- Shares one programmable RPN calculator (steering module plus its code RAM) between two requesters.
- Per job, in order:
  - grants one requester (round-robin);
  - streams its program words into the code RAM from address 0;
  - pulses start and waits for the calculator to halt;
  - returns the top-of-stack result.
- A watchdog aborts runaway programs by pulsing the calculator's reset.

---
 rtl/calc_job_scheduler.sv | 143 ++++++++++++++
 tb/tb_calc_job_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_job_scheduler.sv
// Round-robin arbiter sharing one RPN calculator: loads a program, runs it, returns top of stack.
// Latency: one IDLE->LOAD cycle, one cycle per word, START, run time, then a held response.
// Backpressure: req_ready only while loading the granted requester; response held until resp_ready.
module calc_job_scheduler #(
  parameter int N       = 16,
  parameter int M       = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  input  logic [2*N-1:0] req_data,
  input  logic [1:0]     req_last,
  output logic [1:0]     req_ready,
  output logic [1:0]     resp_valid,
  output logic [N-1:0]   resp_data,
  output logic           resp_timeout,
  input  logic [1:0]     resp_ready,
  output logic           busy,
  output logic [N-1:0]   sm_datain,
  output logic [M-1:0]   sm_addr,
  output logic           sm_wr,
  output logic           sm_start,
  output logic           sm_nrst,
  input  logic [N-1:0]   sm_out,
  input  logic           sm_ready
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [M-1:0]  ADDR_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ABORT, DONE} state_t;

  state_t        state_q, state_nxt;
  logic          grant_q, grant_nxt;
  logic          last_grant_q, last_grant_nxt;
  logic [M-1:0]  addr_q, addr_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic [N-1:0]  result_q, result_nxt;
  logic          tmo_q, tmo_nxt;
  logic [1:0]    resp_valid_q, resp_valid_nxt;
  logic [1:0]    req_ready_c;
  logic          sm_wr_c, sm_start_c;
  logic [N-1:0]  word;

  assign word = grant_q ? req_data[2*N-1:N] : req_data[N-1:0];

  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    addr_nxt       = addr_q;
    timer_nxt      = timer_q;
    result_nxt     = result_q;
    tmo_nxt        = tmo_q;
    req_ready_c    = 2'b00;
    sm_wr_c        = 1'b0;
    sm_start_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sm_ready && (|req_valid)) begin
          grant_nxt = req_valid[~last_grant_q] ? ~last_grant_q : last_grant_q;
          addr_nxt  = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        req_ready_c = grant_q ? 2'b10 : 2'b01;
        if (req_valid[grant_q]) begin
          sm_wr_c  = 1'b1;
          addr_nxt = addr_q + 1'b1;
          // A full RAM ends the job; leftover words start the next one.
          if (req_last[grant_q] || (addr_q == ADDR_MAX)) state_nxt = START;
        end
      end
      START: begin
        sm_start_c = 1'b1;
        timer_nxt  = '0;
        state_nxt  = RUN;
      end
      RUN: begin
        if (sm_ready) begin
          result_nxt = sm_out;
          tmo_nxt    = 1'b0;
          state_nxt  = DONE;
        end else if (timer_q == TMAX) begin
          state_nxt = ABORT;
        end else begin
          timer_nxt = timer_q + 1'b1;
        end
      end
      ABORT: begin
        result_nxt = '0;
        tmo_nxt    = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        if (resp_ready[grant_q]) begin
          last_grant_nxt = grant_q;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    resp_valid_nxt = (state_nxt == DONE) ? (grant_nxt ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      timer_q      <= '0;
      result_q     <= '0;
      tmo_q        <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_nxt;
      grant_q      <= grant_nxt;
      last_grant_q <= last_grant_nxt;
      addr_q       <= addr_nxt;
      timer_q      <= timer_nxt;
      result_q     <= result_nxt;
      tmo_q        <= tmo_nxt;
      resp_valid_q <= resp_valid_nxt;
    end
  end

  // Nothing is accepted or launched while reset is asserted.
  assign req_ready    = rst ? 2'b00 : req_ready_c;
  assign sm_wr        = sm_wr_c & ~rst;
  assign sm_start     = sm_start_c & ~rst;
  assign sm_addr      = addr_q;
  assign sm_datain    = word;
  assign sm_nrst      = ~(rst || (state_q == ABORT));
  assign resp_valid   = resp_valid_q;
  assign resp_data    = result_q;
  assign resp_timeout = tmo_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_calc_job_scheduler.sv
// Bench for calc_job_scheduler with a behavioural RPN calculator attached to the sm_* side.
module tb_calc_job_scheduler;
  localparam int N = 16;
  localparam int M = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [2*N-1:0] req_data = '0;
  logic [1:0]     req_last = 2'b00;
  logic [1:0]     req_ready;
  logic [1:0]     resp_valid;
  logic [N-1:0]   resp_data;
  logic           resp_timeout;
  logic [1:0]     resp_ready = 2'b11;
  logic           busy;
  logic [N-1:0]   sm_datain;
  logic [M-1:0]   sm_addr;
  logic           sm_wr, sm_start, sm_nrst;
  logic [N-1:0]   sm_out;
  logic           sm_ready;

  calc_job_scheduler #(.N(N), .M(M), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .resp_ready(resp_ready), .busy(busy),
    .sm_datain(sm_datain), .sm_addr(sm_addr), .sm_wr(sm_wr), .sm_start(sm_start),
    .sm_nrst(sm_nrst), .sm_out(sm_out), .sm_ready(sm_ready)
  );

  always #5 clk = ~clk;

  // Calculator model: push (MSB 0), op1 negate, op2 add, op7 jump to popped address, 11xx halt.
  logic [N-1:0] code [4];
  logic [N-1:0] stk [16];
  logic [3:0]   sp = 4'd0;
  logic [1:0]   pc = 2'd0;
  logic         running = 1'b0;

  always @(posedge clk) begin
    if (sm_wr) code[sm_addr] <= sm_datain;
    if (!sm_nrst) begin
      running <= 1'b0; sp <= 4'd0; pc <= 2'd0;
    end else if (sm_start) begin
      running <= 1'b1; sp <= 4'd0; pc <= 2'd0;
    end else if (running) begin
      pc <= pc + 2'd1;
      if (code[pc][15:14] == 2'b11) running <= 1'b0;
      else if (!code[pc][15]) begin
        stk[sp] <= code[pc]; sp <= sp + 4'd1;
      end else begin
        case (code[pc][2:0])
          3'd1: stk[sp-4'd1] <= -stk[sp-4'd1];
          3'd2: begin stk[sp-4'd2] <= stk[sp-4'd2] + stk[sp-4'd1]; sp <= sp - 4'd1; end
          3'd7: begin pc <= stk[sp-4'd1][1:0]; sp <= sp - 4'd1; end
          default: ;
        endcase
      end
    end
  end
  assign sm_ready = ~running;
  assign sm_out   = (sp == 4'd0) ? '0 : stk[sp-4'd1];

  typedef struct { int id; logic [N-1:0] d; logic t; } resp_t;
  resp_t         exp_resp[$];
  logic [N+M-1:0] exp_wr[$];
  logic [N:0]    q0[$], q1[$];
  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, start_cnt = 0, abort_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int id, input logic [M-1:0] a, input logic [N-1:0] d, input logic l);
    if (id == 0) q0.push_back({l, d}); else q1.push_back({l, d});
    exp_wr.push_back({a, d});
  endtask

  task automatic push_resp(input int id, input logic [N-1:0] d, input logic t);
    resp_t r;
    r.id = id; r.d = d; r.t = t;
    exp_resp.push_back(r);
  endtask

  task automatic basic0();
    push_word(0, 2'd0, 16'h0003, 1'b0);
    push_word(0, 2'd1, 16'h0004, 1'b0);
    push_word(0, 2'd2, 16'h8002, 1'b0);
    push_word(0, 2'd3, 16'hC000, 1'b1);
    push_resp(0, 16'h0007, 1'b0);
  endtask

  task automatic neg1();
    push_word(1, 2'd0, 16'h0005, 1'b0);
    push_word(1, 2'd1, 16'h8001, 1'b0);
    push_word(1, 2'd2, 16'hC000, 1'b1);
    push_resp(1, 16'hFFFB, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_resp.size() + exp_wr.size()) != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk(name, (n < 2000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // Requester drivers: present the queue head at negedge, retire it once the handshake is seen.
  initial begin
    forever begin
      @(negedge clk);
      req_valid[0] = (q0.size() != 0);
      if (q0.size() != 0) begin req_data[N-1:0] = q0[0][N-1:0]; req_last[0] = q0[0][N]; end
      req_valid[1] = (q1.size() != 0);
      if (q1.size() != 0) begin req_data[2*N-1:N] = q1[0][N-1:0]; req_last[1] = q1[0][N]; end
      #1;
      if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
      if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
    end
  end

  // Monitor: code-RAM writes, responses, start pulses and watchdog aborts.
  initial begin
    resp_t e;
    logic [N+M-1:0] w;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (sm_wr || sm_start) chk("wr_start_exclusive", {sm_wr, sm_start} == 2'b11, 1'b0);
      if (sm_wr) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin w = exp_wr.pop_front(); chk("write_addr_data", {sm_addr, sm_datain}, w); end
      end
      if (sm_start) begin start_cnt++; start_cyc = cyc; end
      if (!rst && !sm_nrst) begin abort_cnt++; chk("abort_delay", cyc - start_cyc, 65); end
      if ((resp_valid & resp_ready) != 2'b00) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", 1'b1, 1'b0);
        else begin
          e = exp_resp.pop_front();
          chk("resp_valid_id", resp_valid, (e.id == 1) ? 2'b10 : 2'b01);
          chk("resp_data", resp_data, e.d);
          chk("resp_timeout", resp_timeout, e.t);
        end
      end
    end
  end

  initial begin
    int n;
    // Both requesters pending from reset: req0 must win the first tie.
    basic0();
    neg1();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_sm_wr", sm_wr, 1'b0);
    chk("rst_sm_start", sm_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_timeout", resp_timeout, 1'b0);
    chk("rst_resp_data", resp_data, 16'h0);
    chk("rst_sm_nrst", sm_nrst, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("nrst_released", sm_nrst, 1'b1);
    wait_done("tie_first_pair");

    @(negedge clk);
    basic0();
    neg1();
    wait_done("tie_second_pair");

    // Response back-pressure on req0 while req1 waits.
    @(negedge clk);
    resp_ready = 2'b10;
    basic0();
    neg1();
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!resp_valid[0] && n < 500);
    chk("bp_resp_arrives", resp_valid[0], 1'b1);
    repeat (10) begin
      chk("bp_resp_valid", resp_valid, 2'b01);
      chk("bp_resp_data", resp_data, 16'h0007);
      chk("bp_busy", busy, 1'b1);
      chk("bp_req_ready", req_ready, 2'b00);
      @(negedge clk); #2;
    end
    chk("bp_req1_pending", q1.size(), 3);
    @(negedge clk);
    resp_ready = 2'b11;
    wait_done("backpressure");

    // Watchdog: push 0, jump to popped 0, forever; then a normal job.
    @(negedge clk);
    push_word(0, 2'd0, 16'h0000, 1'b0);
    push_word(0, 2'd1, 16'h8007, 1'b1);
    push_resp(0, 16'h0000, 1'b1);
    basic0();
    wait_done("watchdog");

    // Six words, no early last: four fill the RAM, two form the next job.
    @(negedge clk);
    push_word(1, 2'd0, 16'h0001, 1'b0);
    push_word(1, 2'd1, 16'h0002, 1'b0);
    push_word(1, 2'd2, 16'h8002, 1'b0);
    push_word(1, 2'd3, 16'hC000, 1'b0);
    push_word(1, 2'd0, 16'h0009, 1'b0);
    push_word(1, 2'd1, 16'hC000, 1'b1);
    push_resp(1, 16'h0003, 1'b0);
    push_resp(1, 16'h0009, 1'b0);
    wait_done("ram_full");

    // Reset after two words of an unfinished program.
    @(negedge clk);
    push_word(0, 2'd0, 16'h0003, 1'b0);
    push_word(0, 2'd1, 16'h0004, 1'b0);
    n = 0;
    while (q0.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("midload_words_taken", q0.size(), 0);
    rst = 1'b1;
    #2;
    chk("midload_rst_req_ready", req_ready, 2'b00);
    chk("midload_rst_nrst", sm_nrst, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midload_after_busy", busy, 1'b0);
    chk("midload_after_req_ready", req_ready, 2'b00);
    chk("midload_after_nrst", sm_nrst, 1'b1);
    chk("midload_after_resp_valid", resp_valid, 2'b00);
    @(negedge clk);
    basic0();
    wait_done("after_midload_reset");

    chk("start_pulses", start_cnt, 11);
    chk("abort_pulses", abort_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
